// File: rtl/audio_mon_pkg.sv
// Shared types and default timing constants for the audio PLL clock monitor.
package audio_mon_pkg;

    localparam int REF_HZ      = 50_000_000;
    localparam int AUDIO_HZ    = 12_288_000;
    // Default gate window is 1 ms of the reference clock.
    localparam int GATE_CYCLES = REF_HZ / 1000;
    localparam int EXP_COUNT   = AUDIO_HZ / 1000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        MEASURE   = 2'd2,
        QUALIFIED = 2'd3
    } mon_state_e;

endpackage

// File: rtl/audio_mon_sync_edge.sv
// Two-flop synchroniser for a single asynchronous bit. With EDGE_DET set, a
// third flop is added and the output becomes a one-cycle rising-edge pulse;
// otherwise the output is the synchronised level.
module audio_mon_sync_edge #(
    parameter bit EDGE_DET = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_out
);
    import audio_mon_pkg::*;

    logic r_sync_p0;
    logic r_sync_p1;

    // Metastability filter: two back-to-back flops on the raw input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= i_async;
            r_sync_p1 <= r_sync_p0;
        end
    end

    generate
        if (EDGE_DET) begin : g_edge
            logic r_sync_p2;

            // Delayed copy of the synchronised level for edge detection.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync_p2 <= 1'b0;
                end else begin
                    r_sync_p2 <= r_sync_p1;
                end
            end

            assign o_out = r_sync_p1 & ~r_sync_p2;
        end else begin : g_level
            assign o_out = r_sync_p1;
        end
    endgenerate

endmodule

// File: rtl/audio_pll_clock_monitor.sv
// Audio PLL clock monitor: counts audio_clk rising edges over a fixed gate
// window of the system clock, checks the count against the expected value
// and qualifies the audio clock after LOCK_GATES consecutive good windows.
// A qualified clock that later goes out of range or loses lock raises a
// sticky fault.
module audio_pll_clock_monitor #(
    parameter int GATE_CYCLES = audio_mon_pkg::GATE_CYCLES,
    parameter int EXP_COUNT   = audio_mon_pkg::EXP_COUNT,
    parameter int TOL         = 16,
    parameter int LOCK_GATES  = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pll_locked,
    input  logic             audio_clk,
    input  logic             fault_clear,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             in_range,
    output logic             clk_good,
    output logic             fault
);
    import audio_mon_pkg::*;

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int GOOD_W = $clog2(LOCK_GATES + 1);
    localparam logic [GATE_W-1:0]    GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GOOD_W-1:0]    GOOD_LAST = GOOD_W'(LOCK_GATES - 1);
    localparam logic signed [CNT_W:0] EXP_S    = (CNT_W+1)'(EXP_COUNT);
    localparam logic signed [CNT_W:0] TOL_S    = (CNT_W+1)'(TOL);

    // Edge counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
        if (inc && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    // Inclusive window |c - EXP_COUNT| <= TOL on a sign-extended difference.
    function automatic logic win_in_range(input logic [CNT_W-1:0] c);
        logic signed [CNT_W:0] diff;
        diff = $signed({1'b0, c}) - EXP_S;
        return (diff >= -TOL_S) && (diff <= TOL_S);
    endfunction

    mon_state_e        r_state;
    mon_state_e        w_next_state;
    logic              w_audio_rise;
    logic              w_lock_sync;
    logic              w_running;
    logic              w_terminal;
    logic              w_win_ok;
    logic              w_fault_set;
    logic [CNT_W-1:0]  w_edge_total;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic [CNT_W-1:0]  r_count;
    logic              r_count_valid;
    logic              r_in_range;
    logic [GOOD_W-1:0] r_good_run;
    logic              r_fault;

    audio_mon_sync_edge #(.EDGE_DET(1'b1)) u_sync_audio (
        .clk     (clk),
        .reset   (reset),
        .i_async (audio_clk),
        .o_out   (w_audio_rise)
    );

    audio_mon_sync_edge #(.EDGE_DET(1'b0)) u_sync_lock (
        .clk     (clk),
        .reset   (reset),
        .i_async (pll_locked),
        .o_out   (w_lock_sync)
    );

    // An edge seen on the terminal gate cycle still belongs to the closing window.
    assign w_edge_total = sat_inc(r_edge_cnt, w_audio_rise);
    assign w_terminal   = (r_gate_cnt == GATE_LAST);
    assign w_win_ok     = win_in_range(w_edge_total);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; enable low overrides everything.
    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:      w_next_state = WAIT_LOCK;
                WAIT_LOCK: if (w_lock_sync) w_next_state = MEASURE;
                MEASURE: begin
                    if (!w_lock_sync) begin
                        w_next_state = WAIT_LOCK;
                    end else if (w_terminal && w_win_ok && (r_good_run == GOOD_LAST)) begin
                        w_next_state = QUALIFIED;
                    end
                end
                QUALIFIED: begin
                    if (!w_lock_sync) begin
                        w_next_state = WAIT_LOCK;
                    end else if (w_terminal && !w_win_ok) begin
                        w_next_state = MEASURE;
                    end
                end
                default:   w_next_state = IDLE;
            endcase
        end
    end

    // FSM outputs: qualified flag, window-run enable and fault trigger.
    always_comb begin
        clk_good    = (r_state == QUALIFIED);
        w_running   = enable && w_lock_sync &&
                      ((r_state == MEASURE) || (r_state == QUALIFIED));
        w_fault_set = enable && (r_state == QUALIFIED) &&
                      (!w_lock_sync || (w_terminal && !w_win_ok));
    end

    // Gate/edge counters and the per-window result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gate_cnt    <= '0;
            r_edge_cnt    <= '0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_in_range    <= 1'b0;
        end else begin
            r_count_valid <= 1'b0;
            if (!w_running) begin
                // Partial windows are discarded whenever measurement stops.
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
            end else if (w_terminal) begin
                r_gate_cnt    <= '0;
                r_edge_cnt    <= '0;
                r_count       <= w_edge_total;
                r_in_range    <= w_win_ok;
                r_count_valid <= 1'b1;
            end else begin
                r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                r_edge_cnt <= w_edge_total;
            end
        end
    end

    // Consecutive in-range window counter, only meaningful while in MEASURE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_good_run <= '0;
        end else if ((r_state != MEASURE) || !w_running) begin
            r_good_run <= '0;
        end else if (w_terminal) begin
            r_good_run <= w_win_ok ? (r_good_run + GOOD_W'(1)) : '0;
        end
    end

    // Sticky fault; a coincident set beats the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_fault_set) begin
            r_fault <= 1'b1;
        end else if (fault_clear) begin
            r_fault <= 1'b0;
        end
    end

    assign count       = r_count;
    assign count_valid = r_count_valid;
    assign in_range    = r_in_range;
    assign fault       = r_fault;

endmodule

// File: tb/tb_audio_pll_clock_monitor.sv
// Directed bench for audio_pll_clock_monitor with a 100-cycle gate window.
// audio_clk comes from a 100-cycle periodic pattern holding pat_n rising
// edges, so every full window sees exactly pat_n edges whatever its phase.
module tb_audio_pll_clock_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pll_locked = 1'b1;
    logic       audio_clk = 1'b0;
    logic       fault_clear = 1'b0;
    logic [7:0] count;
    logic       count_valid;
    logic       in_range;
    logic       clk_good;
    logic       fault;

    // Second instance with a long window for counter saturation.
    logic       audio_fast = 1'b0;
    logic       en2 = 1'b1;
    logic       lock2 = 1'b1;
    logic       fc2 = 1'b0;
    logic [7:0] count2;
    logic       cv2;
    logic       inr2;
    logic       good2;
    logic       fault2;

    int checks = 0;
    int failures = 0;
    int unsigned pat_n = 25;
    int unsigned ph = 0;

    always #5 clk = ~clk;

    audio_pll_clock_monitor #(
        .GATE_CYCLES(100), .EXP_COUNT(25), .TOL(1), .LOCK_GATES(4), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pll_locked(pll_locked),
        .audio_clk(audio_clk), .fault_clear(fault_clear), .count(count),
        .count_valid(count_valid), .in_range(in_range), .clk_good(clk_good),
        .fault(fault)
    );

    audio_pll_clock_monitor #(
        .GATE_CYCLES(600), .EXP_COUNT(25), .TOL(1), .LOCK_GATES(4), .CNT_W(8)
    ) dut_sat (
        .clk(clk), .reset(reset), .enable(en2), .pll_locked(lock2),
        .audio_clk(audio_fast), .fault_clear(fc2), .count(count2),
        .count_valid(cv2), .in_range(inr2), .clk_good(good2),
        .fault(fault2)
    );

    // Audio clock pattern generator, updated away from the sampling edge.
    always @(negedge clk) begin
        ph = (ph == 99) ? 0 : ph + 1;
        audio_clk = (ph < 2 * pat_n) ? ((ph % 2) == 1) : 1'b0;
        audio_fast = ~audio_fast;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Waits for a count_valid pulse; n is cycles waited, or -1 on timeout.
    task automatic wait_cv(input string tag, input int max_cyc, output int n);
        n = 0;
        while (n < max_cyc) begin
            @(negedge clk);
            n++;
            if (count_valid === 1'b1) break;
        end
        if (count_valid !== 1'b1) n = -1;
        chk(tag, (n > 0), 1);
    endtask

    initial begin
        int n;
        int cv_seen;

        // Reset state.
        tick(3);
        chk("rst_count", count, 0);
        chk("rst_count_valid", count_valid, 0);
        chk("rst_in_range", in_range, 0);
        chk("rst_clk_good", clk_good, 0);
        chk("rst_fault", fault, 0);

        // Nominal qualification at 25 edges per window.
        reset = 1'b0;
        enable = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            wait_cv("nom_cv_seen", 300, n);
            if (w > 1) chk("nom_period", n, 100);
            chk("nom_count", count, 25);
            chk("nom_in_range", in_range, 1);
            chk("nom_clk_good", clk_good, (w == 4) ? 1 : 0);
            chk("nom_fault", fault, 0);
        end

        // Upper tolerance bound: 26 edges is still in range.
        pat_n = 26;
        wait_cv("tol26_cv_a", 150, n);
        wait_cv("tol26_cv_b", 150, n);
        chk("tol26_count", count, 26);
        chk("tol26_in_range", in_range, 1);
        chk("tol26_clk_good", clk_good, 1);
        pat_n = 25;
        wait_cv("back25_cv_a", 150, n);
        wait_cv("back25_cv_b", 150, n);
        chk("back25_count", count, 25);

        // Lock loss in QUALIFIED: clk_good drops 3 cycles after the drop.
        pll_locked = 1'b0;
        tick(2);
        chk("lock_good_t2", clk_good, 1);
        tick(1);
        chk("lock_good_t3", clk_good, 0);
        chk("lock_fault_t3", fault, 1);
        tick(7);
        pll_locked = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            wait_cv("relock_cv_seen", 300, n);
            chk("relock_count", count, 25);
            chk("relock_clk_good", clk_good, (w == 4) ? 1 : 0);
        end
        chk("relock_fault_sticky", fault, 1);

        // Fault clear, then clear racing a new fault set.
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        chk("clear_fault", fault, 0);
        wait_cv("race_cv_seen", 150, n);
        pll_locked = 1'b0;
        tick(2);
        fault_clear = 1'b1;
        tick(1);
        chk("race_set_wins", fault, 1);
        tick(1);
        fault_clear = 1'b0;
        chk("race_clear_later", fault, 0);
        tick(6);
        pll_locked = 1'b1;
        for (int w = 1; w <= 4; w++) wait_cv("race_requal_cv", 300, n);
        chk("race_requal_good", clk_good, 1);

        // Enable dropped at gate cycle 50.
        tick(50);
        enable = 1'b0;
        tick(1);
        chk("en_off_clk_good", clk_good, 0);
        cv_seen = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (count_valid === 1'b1) cv_seen++;
        end
        chk("en_off_no_cv", cv_seen, 0);
        chk("en_off_count", count, 25);
        chk("en_off_in_range", in_range, 1);
        chk("en_off_fault", fault, 0);
        enable = 1'b1;
        wait_cv("en_on_cv_seen", 300, n);
        chk("en_on_full_window", n, 102);
        chk("en_on_count", count, 25);

        // Reset at gate cycle 70.
        tick(70);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_cv", count_valid, 0);
        chk("mid_rst_in_range", in_range, 0);
        chk("mid_rst_clk_good", clk_good, 0);
        chk("mid_rst_fault", fault, 0);
        pat_n = 27;
        tick(3);
        reset = 1'b0;

        // 27 edges: out of range, never qualifies.
        for (int w = 1; w <= 5; w++) begin
            wait_cv("tol27_cv_seen", 300, n);
            chk("tol27_count", count, 27);
            chk("tol27_in_range", in_range, 0);
            chk("tol27_clk_good", clk_good, 0);
        end

        // Lower tolerance bound.
        pat_n = 24;
        wait_cv("tol24_cv_a", 150, n);
        wait_cv("tol24_cv_b", 150, n);
        chk("tol24_count", count, 24);
        chk("tol24_in_range", in_range, 1);
        pat_n = 23;
        wait_cv("tol23_cv_a", 150, n);
        wait_cv("tol23_cv_b", 150, n);
        chk("tol23_count", count, 23);
        chk("tol23_in_range", in_range, 0);

        // Saturation: 300 edges per 600-cycle window clamps at 255.
        n = 0;
        while ((n < 700) && (cv2 !== 1'b1)) begin
            @(negedge clk);
            n++;
        end
        chk("sat_cv_seen", cv2, 1);
        chk("sat_count", count2, 255);
        chk("sat_in_range", inr2, 0);
        chk("sat_clk_good", good2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
